steer_en_cond: RTL and testbench
================================

Name: steer_en_cond

Overview:
Condition generator that sits directly upstream of the steering-enable state machine. Accepts left and right load-cell samples from the A2D interface and produces registered, hysteresis-qualified rider-weight and rider-balance flags. Also contains the 1.3 s settle timer; the state machine clears it through clr_tmr and watches tmr_full.

Parameters:
MIN_RIDER_WT, 12'h200, minimum rider weight (sum of both load cells)
WT_HYSTERESIS, 8'h40, hysteresis band applied on each side of MIN_RIDER_WT; must be < MIN_RIDER_WT
TMR_CYCLES, 26'd65_000_000, settle-timer length in clk cycles (1.3 s at 50 MHz); benches override with a small value

Ports:
clk  input  1  50 MHz system clock
rst_n  input  1  asynchronous active-low reset
lft_ld  input  12  left load-cell sample, unsigned
rght_ld  input  12  right load-cell sample, unsigned
ld_vld  input  1  single-cycle strobe; lft_ld and rght_ld are valid in this cycle
clr_tmr  input  1  synchronous clear of the settle timer
sum_gt_min  output  1  sum > MIN_RIDER_WT + WT_HYSTERESIS
sum_lt_min  output  1  sum < MIN_RIDER_WT - WT_HYSTERESIS
diff_gt_1_4  output  1  |lft - rght| > sum/4
diff_gt_15_16  output  1  |lft - rght| > 15/16 of sum
tmr_full  output  1  settle timer has expired
cond_vld  output  1  single-cycle pulse when the four flags update

Behaviour:
- Reset: clk and reset rst_n are fixed as asynchronous active-low, clock clk. On reset:
  - sum_lt_min=1 (no rider present).
  - sum_gt_min, diff_gt_1_4, diff_gt_15_16, tmr_full, cond_vld = 0.
  - All pipeline valid bits are 0 and the timer count is 0.
- Stage 1 (clock edge where ld_vld=1):
  - sum_r = lft_ld + rght_ld, 13 bits, no overflow.
  - diff_r = |lft_ld - rght_ld|, 12 bits; the subtraction is done at 13 bits and the magnitude taken.
  - v1 <= ld_vld.
- Stage 2 (edge where v1=1): all comparisons are unsigned at 13 bits, operands zero-extended.
  - sum_gt_min <= sum_r > (MIN_RIDER_WT + WT_HYSTERESIS).
  - sum_lt_min <= sum_r < (MIN_RIDER_WT - WT_HYSTERESIS).
  - diff_gt_1_4 <= diff_r > (sum_r >> 2).
  - diff_gt_15_16 <= diff_r > (sum_r - (sum_r >> 4)); shift truncates.
  - cond_vld <= 1; otherwise cond_vld <= 0.
- Latency and throughput:
  - Flags change exactly 2 clk after the ld_vld edge.
  - Flags hold their value between updates.
  - Fully pipelined: back-to-back ld_vld is accepted every cycle, and the results emerge in order with no drops.
- Comparison boundaries:
  - Strict compares: sum equal to either threshold asserts neither weight flag.
  - sum_gt_min and sum_lt_min are never both 1.
  - Both may be 0 (inside the band).
  - sum=0, diff=0 gives diff flags 0.
- Timer:
  - 26-bit counter; clr_tmr has priority and sets cnt to 0 on the next edge.
  - Otherwise cnt increments each clk and saturates at TMR_CYCLES-1.
  - tmr_full = (cnt == TMR_CYCLES-1), decoded from the registered count.
  - tmr_full asserts TMR_CYCLES-1 edges after the clearing edge and stays high until the next clr_tmr.
  - clr_tmr while tmr_full=1 drops tmr_full after 1 edge.
  - The timer runs independently of ld_vld.
- Reset mid-operation: asynchronously forces all reset values, discards in-flight samples (no cond_vld afterwards) and zeroes the timer.

Test Plan:
1. Assert rst_n=0 and hold ld_vld=0 -> sum_lt_min=1; sum_gt_min, diff_gt_1_4, diff_gt_15_16, tmr_full, cond_vld all 0; all unchanged for 20 clk after release.
2. Weight hysteresis (defaults):
   - lft=rght=0x120 (sum 0x240) -> both weight flags 0 at ld_vld+2, cond_vld pulse.
   - lft=0x121, rght=0x120 -> sum_gt_min=1.
   - lft=rght=0x0E0 (sum 0x1C0) -> both 0.
   - lft=0x0DF, rght=0x0E0 -> sum_lt_min=1.
3. Balance flags:
   - lft=0x200, rght=0x100 (sum 0x300, diff 0x100 > 0xC0) -> diff_gt_1_4=1, diff_gt_15_16=0 (limit 0x2D0).
   - lft=0x300, rght=0 -> both 1.
   - lft=rght=0x180 -> both 0.
4. Timer with TMR_CYCLES=16:
   - Pulse clr_tmr -> tmr_full rises exactly 15 edges after the clear edge and holds for 50 clk.
   - Another clr_tmr -> tmr_full low on the next cycle.
   - Holding clr_tmr high keeps tmr_full=0.
5. Pipelining: ld_vld on 3 consecutive cycles with sums 0x300, 0x100, 0x240 -> 3 consecutive cond_vld pulses; sum_gt_min/sum_lt_min sequence (1,0), (0,1), (0,0).
6. Reset mid-operation: assert rst_n=0 one cycle after an ld_vld with sum 0x300, while the timer is at count 10 -> no cond_vld, sum_gt_min=0, sum_lt_min=1, timer restarts from 0 after release.

Source files
------------

// File: rtl/steer_en_cond.sv
// Rider weight/balance condition generator and settle timer that feed the
// steering-enable state machine. Two-stage pipeline: sum/|diff|, then compares.
module steer_en_cond #(
    parameter logic [11:0] MIN_RIDER_WT  = 12'h200,
    parameter logic [7:0]  WT_HYSTERESIS = 8'h40,
    parameter logic [25:0] TMR_CYCLES    = 26'd65_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    input  logic        ld_vld,
    input  logic        clr_tmr,
    output logic        sum_gt_min,
    output logic        sum_lt_min,
    output logic        diff_gt_1_4,
    output logic        diff_gt_15_16,
    output logic        tmr_full,
    output logic        cond_vld
);

    localparam logic [12:0] WT_HI    = {1'b0, MIN_RIDER_WT} + {5'b0, WT_HYSTERESIS};
    localparam logic [12:0] WT_LO    = {1'b0, MIN_RIDER_WT} - {5'b0, WT_HYSTERESIS};
    localparam logic [25:0] TMR_LAST = TMR_CYCLES - 26'd1;

    // Stage 1 registers
    logic [12:0] sum_q, sum_d;
    logic [11:0] diff_q, diff_d;
    logic        v1_q;

    // Stage 2 registers
    logic        gt_q, gt_d;
    logic        lt_q, lt_d;
    logic        d14_q, d14_d;
    logic        d1516_q, d1516_d;
    logic        cvld_q;

    logic [25:0] cnt_q, cnt_d;

    logic [12:0] sub_raw;
    logic [12:0] sub_mag;
    logic [12:0] diff_ext;

    always_comb begin
        sub_raw = {1'b0, lft_ld} - {1'b0, rght_ld};
        sub_mag = sub_raw[12] ? (13'd0 - sub_raw) : sub_raw;
        sum_d   = sum_q;
        diff_d  = diff_q;
        if (ld_vld) begin
            sum_d  = {1'b0, lft_ld} + {1'b0, rght_ld};
            diff_d = sub_mag[11:0];
        end
    end

    always_comb begin
        diff_ext = {1'b0, diff_q};
        gt_d     = gt_q;
        lt_d     = lt_q;
        d14_d    = d14_q;
        d1516_d  = d1516_q;
        if (v1_q) begin
            gt_d    = sum_q > WT_HI;
            lt_d    = sum_q < WT_LO;
            d14_d   = diff_ext > (sum_q >> 2);
            d1516_d = diff_ext > (sum_q - (sum_q >> 4));
        end
    end

    // Clear wins over counting; the count parks at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_tmr) begin
            cnt_d = 26'd0;
        end else if (cnt_q != TMR_LAST) begin
            cnt_d = cnt_q + 26'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= 13'd0;
            diff_q  <= 12'd0;
            v1_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b1;
            d14_q   <= 1'b0;
            d1516_q <= 1'b0;
            cvld_q  <= 1'b0;
            cnt_q   <= 26'd0;
        end else begin
            sum_q   <= sum_d;
            diff_q  <= diff_d;
            v1_q    <= ld_vld;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
            d14_q   <= d14_d;
            d1516_q <= d1516_d;
            cvld_q  <= v1_q;
            cnt_q   <= cnt_d;
        end
    end

    assign sum_gt_min    = gt_q;
    assign sum_lt_min    = lt_q;
    assign diff_gt_1_4   = d14_q;
    assign diff_gt_15_16 = d1516_q;
    assign cond_vld      = cvld_q;
    assign tmr_full      = (cnt_q == TMR_LAST);

endmodule

// File: tb/tb_steer_en_cond.sv
// Directed bench for steer_en_cond: table of load-cell vectors plus
// hand-written timer, pipelining and mid-operation reset sequences.
module tb_steer_en_cond;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        ld_vld;
    logic        clr_tmr;
    logic        sum_gt_min;
    logic        sum_lt_min;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;
    logic        tmr_full;
    logic        cond_vld;

    int checks = 0;
    int errors = 0;

    steer_en_cond #(
        .MIN_RIDER_WT (12'h200),
        .WT_HYSTERESIS(8'h40),
        .TMR_CYCLES   (26'd16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .lft_ld       (lft_ld),
        .rght_ld      (rght_ld),
        .ld_vld       (ld_vld),
        .clr_tmr      (clr_tmr),
        .sum_gt_min   (sum_gt_min),
        .sum_lt_min   (sum_lt_min),
        .diff_gt_1_4  (diff_gt_1_4),
        .diff_gt_15_16(diff_gt_15_16),
        .tmr_full     (tmr_full),
        .cond_vld     (cond_vld)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] lft;
        logic [11:0] rght;
        logic        gt;
        logic        lt;
        logic        d14;
        logic        d1516;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s = %b", name, act);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_flags(input string tag, input logic gt, input logic lt,
                             input logic d14, input logic d1516);
        chk({tag, ".sum_gt_min"}, sum_gt_min, gt);
        chk({tag, ".sum_lt_min"}, sum_lt_min, lt);
        chk({tag, ".diff_gt_1_4"}, diff_gt_1_4, d14);
        chk({tag, ".diff_gt_15_16"}, diff_gt_15_16, d1516);
    endtask

    task automatic clear_timer();
        clr_tmr = 1'b1;
        tick(1);
        clr_tmr = 1'b0;
    endtask

    initial begin
        logic hold_ok;
        logic seen_cvld;
        vecs[0] = '{12'h120, 12'h120, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{12'h121, 12'h120, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{12'h0E0, 12'h0E0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{12'h0DF, 12'h0E0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{12'h200, 12'h100, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{12'h300, 12'h000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{12'h180, 12'h180, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{12'h000, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{12'h000, 12'hFFF, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[9] = '{12'h0F8, 12'h008, 1'b0, 1'b1, 1'b1, 1'b0};

        rst_n   = 1'b0;
        lft_ld  = 12'h0;
        rght_ld = 12'h0;
        ld_vld  = 1'b0;
        clr_tmr = 1'b0;

        // 1. reset state and quiet period after release
        tick(3);
        chk_flags("rst", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rst.tmr_full", tmr_full, 1'b0);
        chk("rst.cond_vld", cond_vld, 1'b0);
        rst_n = 1'b1;
        hold_ok = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (sum_gt_min !== 1'b0 || sum_lt_min !== 1'b1 || diff_gt_1_4 !== 1'b0 ||
                diff_gt_15_16 !== 1'b0 || cond_vld !== 1'b0)
                hold_ok = 1'b0;
            if (c < 14 && tmr_full !== 1'b0)
                hold_ok = 1'b0;
        end
        chk("idle_20clk_unchanged", hold_ok, 1'b1);

        // 2/3. table-driven vectors
        for (int i = 0; i < 10; i++) begin
            lft_ld  = vecs[i].lft;
            rght_ld = vecs[i].rght;
            ld_vld  = 1'b1;
            tick(1);
            ld_vld  = 1'b0;
            lft_ld  = 12'h0;
            rght_ld = 12'h0;
            chk($sformatf("v%0d.cvld_early", i), cond_vld, 1'b0);
            tick(1);
            chk($sformatf("v%0d.cond_vld", i), cond_vld, 1'b1);
            chk_flags($sformatf("v%0d", i), vecs[i].gt, vecs[i].lt, vecs[i].d14, vecs[i].d1516);
            tick(1);
            chk($sformatf("v%0d.cvld_single", i), cond_vld, 1'b0);
            chk_flags($sformatf("v%0d.hold", i), vecs[i].gt, vecs[i].lt, vecs[i].d14, vecs[i].d1516);
        end

        // 4. settle timer, length 16
        clear_timer();
        tick(14);
        chk("tmr.not_full_at_14", tmr_full, 1'b0);
        tick(1);
        chk("tmr.full_at_15", tmr_full, 1'b1);
        hold_ok = 1'b1;
        for (int c = 0; c < 50; c++) begin
            tick(1);
            if (tmr_full !== 1'b1) hold_ok = 1'b0;
        end
        chk("tmr.holds_50clk", hold_ok, 1'b1);
        clear_timer();
        chk("tmr.clr_drops_full", tmr_full, 1'b0);
        clr_tmr = 1'b1;
        hold_ok = 1'b1;
        for (int c = 0; c < 30; c++) begin
            tick(1);
            if (tmr_full !== 1'b0) hold_ok = 1'b0;
        end
        clr_tmr = 1'b0;
        chk("tmr.clr_held_low", hold_ok, 1'b1);

        // 5. back-to-back samples: sums 0x300, 0x100, 0x240
        for (int j = 0; j < 6; j++) begin
            if (j < 3) begin
                ld_vld  = 1'b1;
                lft_ld  = (j == 0) ? 12'h180 : (j == 1) ? 12'h080 : 12'h120;
                rght_ld = lft_ld;
            end else begin
                ld_vld = 1'b0;
            end
            if (j >= 2 && j <= 4) begin
                chk($sformatf("pipe%0d.cond_vld", j - 2), cond_vld, 1'b1);
                chk($sformatf("pipe%0d.gt", j - 2), sum_gt_min, (j == 2));
                chk($sformatf("pipe%0d.lt", j - 2), sum_lt_min, (j == 3));
            end
            if (j == 5)
                chk("pipe.cvld_end", cond_vld, 1'b0);
            tick(1);
        end

        // 6. reset mid-operation: sample in flight, timer at 10
        clear_timer();
        tick(9);
        lft_ld  = 12'h180;
        rght_ld = 12'h180;
        ld_vld  = 1'b1;
        tick(1);
        ld_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst.async_gt", sum_gt_min, 1'b0);
        chk("mrst.async_lt", sum_lt_min, 1'b1);
        chk("mrst.async_cvld", cond_vld, 1'b0);
        tick(2);
        rst_n = 1'b1;
        seen_cvld = 1'b0;
        for (int c = 0; c < 14; c++) begin
            tick(1);
            if (cond_vld !== 1'b0) seen_cvld = 1'b1;
        end
        chk("mrst.no_cond_vld", seen_cvld, 1'b0);
        chk("mrst.gt_after", sum_gt_min, 1'b0);
        chk("mrst.lt_after", sum_lt_min, 1'b1);
        chk("mrst.tmr_not_full_14", tmr_full, 1'b0);
        tick(1);
        chk("mrst.tmr_full_15", tmr_full, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
